sopc_mem_arbiter: RTL and testbench
===================================

# sopc_mem_arbiter

- Parametrised unified-memory subsystem for the next-generation minimal SOPC.
- Replaces separate instruction ROM and data RAM: one single-port synchronous word RAM shared by the CPU instruction-fetch port and data port.
- Arbitrates between the two ports; inserts configurable wait states; supports byte-lane writes; flags out-of-range accesses.
- Each port receives a one-cycle ready pulse, which the CPU uses as its stall-release.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, power of two.
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- WAIT_CYCLES, 0, extra cycles inserted in ACCESS before the RAM operation (0..15).
- PRIO_MODE, 0, 0 = fixed priority (data port wins), 1 = round-robin.
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_ce  in  1  instruction-fetch request.
- i_addr  in  32  instruction byte address.
- i_rdata  out  DATA_W  fetched word.
- i_ready  out  1  one-cycle completion pulse, instruction port.
- i_err  out  1  out-of-range flag, valid with i_ready.
- d_ce  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_sel  in  DATA_W/8  byte-lane enables; bit n covers bits 8n+7:8n.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data.
- d_ready  out  1  one-cycle completion pulse, data port.
- d_err  out  1  out-of-range flag, valid with d_ready.

## Operation
- Word index = addr >> log2(DATA_W/8). Low byte-offset bits are ignored.
- An address is out of range when any word-index bit at or above DEPTH_LOG2 is set.
- FSM states:
  - IDLE: arbitrate on sampled requests. No request: stay. Otherwise latch winner's port id, addr, we, sel and wdata, load wait counter with WAIT_CYCLES, go to ACCESS.
  - ACCESS: counter > 0: decrement and stay. Counter == 0: perform RAM op at clock edge, go to RESP.
  - RESP: assert granted port's ready (and err if out of range) for exactly one cycle, then go to IDLE.
- Arbitration, both ce high in IDLE:
  - PRIO_MODE 0: data port granted.
  - PRIO_MODE 1: grant the port not served last. last_grant updates on every grant.
- Instruction port is read-only; it has no write path.
- Data write:
  - Only lanes with d_sel bit set change.
  - d_sel all-zero: no RAM change, normal response.
  - d_rdata is not updated by writes.
- Read: RAM word registered into the granted port's rdata at the end of ACCESS. Holds until that port's next read response.
- Out-of-range access:
  - No RAM write.
  - rdata loaded with 0.
  - err asserted alongside ready.
- Request inputs are only sampled in IDLE. Changes during ACCESS/RESP have no effect on the current transaction.
- Masters hold ce/addr/data until ready; a new request may be presented from the cycle after ready.
- A losing port's request stays pending and is granted in the next IDLE cycle.
- Data port with d_ce=0 ignores d_we.

## Timing
- Request present in IDLE cycle 0 → ready high in cycle 2+WAIT_CYCLES.
- rdata valid from that cycle onward.
- Minimum spacing between grants is 3+WAIT_CYCLES cycles.
- Write commits at the clock edge ending the last ACCESS cycle; a read issued afterwards returns the new data.
- Reset values:
  - state IDLE; counter 0; ready and err low on both ports.
  - i_rdata and d_rdata 0.
  - last_grant = instruction, so the first round-robin conflict goes to data.
- Reset asserted mid-transaction:
  - Outputs return to reset values immediately (asynchronous).
  - Transaction abandoned; no ready is issued.
  - A write not yet committed is dropped.
  - RAM contents are not cleared.
- Simultaneous reset release and ce: request sampled in the first IDLE cycle after release.

## Test plan
- WAIT_CYCLES=0: write d_addr=0x10, d_sel=4'b1111, d_wdata=0xDEADBEEF; then i_addr=0x10 read → i_ready in cycle 2 of each transaction, i_rdata=0xDEADBEEF, i_err=0.
- Byte lanes: word 0x20 preset to 0x11223344; write d_sel=4'b0101, d_wdata=0xAABBCCDD; read back → 0x11BB33DD.
- PRIO_MODE=0, both ce high continuously:
  - data always granted while d_ce held.
  - d_ce dropped after its ready → instruction granted at next IDLE; i_ready 3 cycles after d_ready.
- PRIO_MODE=1, both ce held for four transactions → grants alternate D, I, D, I; no port waits more than one transaction.
- WAIT_CYCLES=3:
  - read latency 5 cycles.
  - Address DEPTH_LOG2=10 byte 0x1000 → d_ready with d_err=1, d_rdata=0; RAM unchanged on a following in-range read.
- Write in flight, rst pulsed in ACCESS:
  - ready never asserts; outputs 0.
  - After release, reading that address returns the old value.
  - Two-cycle rst mid-RESP clears d_ready immediately.

Source files
------------

// File: rtl/sopc_mem_arbiter.sv
// Unified single-port word RAM shared by the instruction-fetch and data ports of the SOPC CPU.
// Per transaction: IDLE -> ACCESS (+WAIT_CYCLES) -> RESP with a one-cycle ready pulse to the granted port.
module sopc_mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0,
    parameter int PRIO_MODE   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ce,
    input  logic [31:0]         i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    output logic                i_err,
    input  logic                d_ce,
    input  logic                d_we,
    input  logic [31:0]         d_addr,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                d_err
);
    localparam int NB    = DATA_W / 8;
    localparam int BL    = $clog2(NB);
    localparam int IW    = 32 - BL;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_port_d;
    logic                  r_last_d;
    logic                  r_we;
    logic                  r_oor;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [NB-1:0]         r_sel;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_i_rdata;
    logic [DATA_W-1:0]     r_d_rdata;
    logic [DATA_W-1:0]     r_mem [0:DEPTH-1];

    logic [IW-1:0]         w_i_widx;
    logic [IW-1:0]         w_d_widx;
    logic                  w_i_oor;
    logic                  w_d_oor;
    logic                  w_req;
    logic                  w_gnt_d;
    logic                  w_do_op;
    logic [DATA_W-1:0]     w_rd_word;
    logic                  w_unused;

    assign w_i_widx = i_addr[31:BL];
    assign w_d_widx = d_addr[31:BL];
    assign w_i_oor  = |w_i_widx[IW-1:DEPTH_LOG2];
    assign w_d_oor  = |w_d_widx[IW-1:DEPTH_LOG2];
    assign w_unused = ^{i_addr, d_addr};

    // Round-robin: data wins a conflict unless it was the last port served.
    assign w_req     = i_ce | d_ce;
    assign w_gnt_d   = d_ce & (~i_ce | (PRIO_MODE == 0) | ~r_last_d);
    assign w_do_op   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_rd_word = r_oor ? '0 : r_mem[r_idx];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_port_d  <= 1'b0;
            r_last_d  <= 1'b0;
            r_we      <= 1'b0;
            r_oor     <= 1'b0;
            r_idx     <= '0;
            r_sel     <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_port_d <= w_gnt_d;
                        r_last_d <= w_gnt_d;
                        r_we     <= w_gnt_d & d_we;
                        r_oor    <= w_gnt_d ? w_d_oor : w_i_oor;
                        r_idx    <= w_gnt_d ? w_d_widx[DEPTH_LOG2-1:0] : w_i_widx[DEPTH_LOG2-1:0];
                        r_sel    <= d_sel;
                        r_wdata  <= d_wdata;
                        r_cnt    <= 4'(WAIT_CYCLES);
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_we) begin
                        if (r_port_d) r_d_rdata <= w_rd_word;
                        else          r_i_rdata <= w_rd_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM contents survive reset; a reset forces IDLE so an uncommitted write never fires.
    always_ff @(posedge clk) begin
        if (w_do_op && r_we && !r_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

    assign i_ready = (r_state == S_RESP) & ~r_port_d;
    assign d_ready = (r_state == S_RESP) &  r_port_d;
    assign i_err   = i_ready & r_oor;
    assign d_err   = d_ready & r_oor;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Bench for sopc_mem_arbiter: two instances (no wait/fixed priority, 3 waits/round-robin)
// checked against a transaction-level memory and arbitration model.
module tb_sopc_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        i_ce    [2];
    logic [31:0] i_addr  [2];
    logic [31:0] i_rdata [2];
    logic        i_ready [2];
    logic        i_err   [2];
    logic        d_ce    [2];
    logic        d_we    [2];
    logic [31:0] d_addr  [2];
    logic [3:0]  d_sel   [2];
    logic [31:0] d_wdata [2];
    logic [31:0] d_rdata [2];
    logic        d_ready [2];
    logic        d_err   [2];

    sopc_mem_arbiter #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0), .PRIO_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_ce(i_ce[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ready(i_ready[0]), .i_err(i_err[0]),
        .d_ce(d_ce[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_sel(d_sel[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_ready(d_ready[0]), .d_err(d_err[0]));

    sopc_mem_arbiter #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3), .PRIO_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_ce(i_ce[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ready(i_ready[1]), .i_err(i_err[1]),
        .d_ce(d_ce[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_sel(d_sel[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_ready(d_ready[1]), .d_err(d_err[1]));

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_mem [2][1024];
    logic [31:0] m_ird [2];
    logic [31:0] m_drd [2];
    bit          m_last_d [2];

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit is_d;
        int t;
    } ev_t;

    vec_t tbl [14];

    function automatic int wc(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit rr(input int k);
        return (k == 1);
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return (a >> 2) >= 32'd1024;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h, required %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ird[k]    = '0;
            m_drd[k]    = '0;
            m_last_d[k] = 1'b0;
        end
    endtask

    task automatic model_txn(input int k, input bit is_d, input bit we, input logic [31:0] a,
                             input logic [3:0] sel, input logic [31:0] wd);
        int w;
        w = int'(a[11:2]);
        m_last_d[k] = is_d;
        if (is_d && we) begin
            if (!oor(a))
                for (int b = 0; b < 4; b++)
                    if (sel[b]) m_mem[k][w][8*b +: 8] = wd[8*b +: 8];
        end else begin
            if (is_d) m_drd[k] = oor(a) ? 32'h0 : m_mem[k][w];
            else      m_ird[k] = oor(a) ? 32'h0 : m_mem[k][w];
        end
    endtask

    task automatic run_txn(input int k, input bit is_d, input bit we, input logic [31:0] a,
                           input logic [3:0] sel, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er, output logic oth);
        lat = -1; rd = '0; er = 1'b0; oth = 1'b0;
        if (is_d) begin
            d_ce[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_sel[k] = sel; d_wdata[k] = wd;
        end else begin
            i_ce[k] = 1'b1; i_addr[k] = a;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (is_d ? d_ready[k] : i_ready[k]) begin
                lat = n;
                rd  = is_d ? d_rdata[k] : i_rdata[k];
                er  = is_d ? d_err[k]   : i_err[k];
                oth = is_d ? i_ready[k] : d_ready[k];
                break;
            end
        end
        i_ce[k] = 1'b0;
        d_ce[k] = 1'b0;
        d_we[k] = 1'($urandom);
    endtask

    task automatic txn_now(input int k, input bit is_d, input bit we, input logic [31:0] a,
                           input logic [3:0] sel, input logic [31:0] wd, input string nm,
                           output logic [31:0] rd, output logic er);
        int   lat;
        logic oth;
        run_txn(k, is_d, we, a, sel, wd, lat, rd, er, oth);
        model_txn(k, is_d, we, a, sel, wd);
        chk({nm, " latency"}, lat, 2 + wc(k));
        chk({nm, " err"}, er, oor(a));
        chk({nm, " rdata"}, rd, is_d ? m_drd[k] : m_ird[k]);
        chk({nm, " other rdata"}, is_d ? i_rdata[k] : d_rdata[k], is_d ? m_ird[k] : m_drd[k]);
        chk({nm, " other ready"}, oth, 1'b0);
        @(negedge clk);
        chk({nm, " ready width"}, is_d ? d_ready[k] : i_ready[k], 1'b0);
    endtask

    task automatic txn(input int k, input bit is_d, input bit we, input logic [31:0] a,
                       input logic [3:0] sel, input logic [31:0] wd, input string nm,
                       output logic [31:0] rd, output logic er);
        @(negedge clk);
        txn_now(k, is_d, we, a, sel, wd, nm, rd, er);
    endtask

    // Both ports request together; data holds for nd grants, instruction for ni grants.
    task automatic conflict(input int k, input int nd, input int ni, input string nm);
        ev_t qe[$];
        ev_t qo[$];
        ev_t e;
        int  nd_left, ni_left, t, gd, gi;
        bit  last, win_d;
        nd_left = nd; ni_left = ni; t = 0; gd = 0; gi = 0; last = m_last_d[k];
        while (nd_left > 0 || ni_left > 0) begin
            if (nd_left > 0 && ni_left > 0) win_d = !rr(k) || !last;
            else                            win_d = (nd_left > 0);
            e.is_d = win_d; e.t = t + 2 + wc(k);
            qe.push_back(e);
            last = win_d;
            if (win_d) nd_left--; else ni_left--;
            t += 3 + wc(k);
        end
        @(negedge clk);
        d_ce[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h08; d_sel[k] = 4'($urandom);
        i_ce[k] = 1'b1; i_addr[k] = 32'h0C;
        for (int n = 1; n <= (nd + ni) * (3 + wc(k)) + 10; n++) begin
            @(negedge clk);
            if (d_ready[k]) begin
                e.is_d = 1'b1; e.t = n; qo.push_back(e); gd++;
                chk({nm, " D rdata"}, d_rdata[k], m_mem[k][2]);
                if (gd >= nd) d_ce[k] = 1'b0;
            end
            if (i_ready[k]) begin
                e.is_d = 1'b0; e.t = n; qo.push_back(e); gi++;
                chk({nm, " I rdata"}, i_rdata[k], m_mem[k][3]);
                if (gi >= ni) i_ce[k] = 1'b0;
            end
            if (gd >= nd && gi >= ni) break;
        end
        d_ce[k] = 1'b0;
        i_ce[k] = 1'b0;
        chk({nm, " grant count"}, qo.size(), qe.size());
        foreach (qe[j]) begin
            if (j < qo.size()) begin
                chk($sformatf("%s grant%0d port", nm, j), qo[j].is_d, qe[j].is_d);
                chk($sformatf("%s grant%0d cycle", nm, j), qo[j].t, qe[j].t);
            end
            model_txn(k, qe[j].is_d, 1'b0, qe[j].is_d ? 32'h08 : 32'h0C, 4'h0, 32'h0);
        end
    endtask

    task automatic rst_mid_access(input int k, input int at_n);
        logic [31:0] old;
        int          nrdy;
        old = m_mem[k][12];
        @(negedge clk);
        d_ce[k] = 1'b1; d_we[k] = 1'b1; d_addr[k] = 32'h30; d_sel[k] = 4'hF; d_wdata[k] = ~old;
        repeat (at_n) @(negedge clk);
        chk("rstA no early ready", d_ready[k], 1'b0);
        rst = 1'b1;
        #1;
        chk("rstA d_ready", d_ready[k], 1'b0);
        chk("rstA d_err", d_err[k], 1'b0);
        chk("rstA d_rdata", d_rdata[k], 32'h0);
        chk("rstA i_rdata", i_rdata[k], 32'h0);
        d_ce[k] = 1'b0; d_we[k] = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_ready[k] || i_ready[k]) nrdy++;
        end
        chk("rstA no ready after", nrdy, 0);
    endtask

    task automatic rst_mid_resp(input int k);
        bit          got;
        int          nrdy;
        logic [31:0] rd;
        logic        er;
        got = 1'b0;
        @(negedge clk);
        d_ce[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h34;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (d_ready[k]) begin got = 1'b1; break; end
        end
        chk("rstR ready seen", got, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstR d_ready", d_ready[k], 1'b0);
        chk("rstR d_rdata", d_rdata[k], 32'h0);
        d_ce[k] = 1'b0;
        model_reset();
        nrdy = 0;
        repeat (2) begin
            @(negedge clk);
            if (d_ready[k] || i_ready[k]) nrdy++;
        end
        chk("rstR no ready in reset", nrdy, 0);
        rst = 1'b0;
        txn_now(k, 1'b0, 1'b0, 32'h34, 4'h0, 32'h0, "rstR release fetch", rd, er);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;

        tbl[0]  = '{1'b1, 1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h10,       4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 32'h20,       4'hF, 32'h11223344, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'h20,       4'h5, 32'hAABBCCDD, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h20,       4'h0, 32'h0,        1'b1, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 32'h24,       4'hF, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h24,       4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h26,       4'h0, 32'h0,        1'b1, 32'h5A5A5A5A, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h00,       4'hF, 32'h01020304, 1'b0, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b1, 32'h1000,     4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'h1000,     4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
        tbl[11] = '{1'b1, 1'b0, 32'h00,       4'h0, 32'h0,        1'b1, 32'h01020304, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'hFFFFFFFC, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 1'b0, 32'h21,       4'h0, 32'h0,        1'b1, 32'h11BB33DD, 1'b0};

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_ce[k] = 1'b0; i_addr[k] = '0; d_ce[k] = 1'b0; d_we[k] = 1'b0;
            d_addr[k] = '0; d_sel[k] = '0; d_wdata[k] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset i_ready%0d", k), i_ready[k], 1'b0);
            chk($sformatf("reset i_err%0d", k),   i_err[k],   1'b0);
            chk($sformatf("reset i_rdata%0d", k), i_rdata[k], 32'h0);
            chk($sformatf("reset d_ready%0d", k), d_ready[k], 1'b0);
            chk($sformatf("reset d_err%0d", k),   d_err[k],   1'b0);
            chk($sformatf("reset d_rdata%0d", k), d_rdata[k], 32'h0);
        end
        rst = 1'b0;

        for (int k = 0; k < 2; k++) begin
            foreach (tbl[j]) begin
                txn(k, tbl[j].is_d, tbl[j].we, tbl[j].addr, tbl[j].sel, tbl[j].wd,
                    $sformatf("tbl%0d.%0d", k, j), rd, er);
                chk($sformatf("tbl%0d.%0d err vec", k, j), er, tbl[j].exp_err);
                if (tbl[j].chk_rd) chk($sformatf("tbl%0d.%0d rdata vec", k, j), rd, tbl[j].exp_rd);
            end
        end

        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 16; w++)
                txn(k, 1'b1, 1'b1, 32'(w * 4), 4'hF, $urandom, $sformatf("init%0d.%0d", k, w), rd, er);

        conflict(0, 2, 1, "prio0 conflict");
        conflict(1, 2, 2, "rr conflict");

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
                else                           a = $urandom_range(0, 63);
                txn(k, 1'($urandom), 1'($urandom), a, 4'($urandom), $urandom,
                    $sformatf("rand%0d.%0d", k, i), rd, er);
            end
            for (int i = 0; i < 8; i++)
                conflict(k, $urandom_range(1, 3), $urandom_range(1, 3), $sformatf("rconf%0d.%0d", k, i));
        end

        rst_mid_access(0, 1);
        conflict(1, 1, 1, "rr first after reset");
        txn(0, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0, "rstA readback", rd, er);
        rst_mid_resp(0);
        rst_mid_access(1, 3);
        txn(1, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0, "rstA1 readback", rd, er);
        rst_mid_resp(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
